// File: rtl/ntt_addr_gen.sv
// Address/enable sequencer for the in-place 7-layer Kyber forward NTT over a 512x12 dual-port RAM.
// One butterfly every two cycles: reads on even phase, delayed write-back lands on odd phase.
module ntt_addr_gen #(
    parameter int BF_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       poly_sel,
    output logic       busy,
    output logic       done,
    output logic [8:0] addr_a,
    output logic [8:0] addr_b,
    output logic       we_a,
    output logic       we_b,
    output logic       rd_issue,
    output logic       bf_in_valid,
    output logic [6:0] zeta_idx,
    output logic [2:0] layer
);

    localparam int DEPTH = 1 + BF_LAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [6:0]       r_bfly;
    logic             r_phase;
    logic [2:0]       r_layer;
    logic             r_poly;

    logic [DEPTH-1:0] r_vld_p;
    logic [7:0]       r_ja_p [DEPTH];
    logic [7:0]       r_jb_p [DEPTH];
    logic [6:0]       r_k_p0;

    logic [2:0]       w_sh7;
    logic [3:0]       w_sh8;
    logic [7:0]       w_len;
    logic [6:0]       w_mask;
    logic [6:0]       w_grp;
    logic [6:0]       w_pow;
    logic [7:0]       w_j;
    logic [7:0]       w_jl;
    logic [6:0]       w_k;
    logic             w_rd;
    logic             w_wr;
    logic             w_inflight;

    // Butterfly b of layer l: group g = b >> (7-l), j = (g << (8-l)) | (b mod len)
    always_comb begin
        w_sh7  = 3'd7 - r_layer;
        w_sh8  = 4'd8 - {1'b0, r_layer};
        w_len  = 8'd1 << w_sh7;
        w_mask = (7'd1 << w_sh7) - 7'd1;
        w_grp  = r_bfly >> w_sh7;
        w_pow  = 7'd1 << r_layer;
        w_j    = ({1'b0, w_grp} << w_sh8) | {1'b0, r_bfly & w_mask};
        w_jl   = w_j + w_len;
        w_k    = w_pow + w_grp;
        w_rd   = (r_state == S_RUN) && !r_phase;
        w_wr   = r_vld_p[DEPTH-1];
    end

    // Only stages ahead of the output matter: the output stage is being written this cycle.
    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_inflight = w_inflight | r_vld_p[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_rd && (r_bfly == 7'd127)) w_next = S_DRAIN;
            S_DRAIN: if (!w_inflight) w_next = (r_layer == 3'd6) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_issue    = w_rd;
        we_a        = w_wr;
        we_b        = w_wr;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        bf_in_valid = r_vld_p[0];
        zeta_idx    = r_vld_p[0] ? r_k_p0 : 7'd0;
        layer       = r_layer;
        addr_a      = 9'd0;
        addr_b      = 9'd0;
        if (w_rd) begin
            addr_a = {r_poly, w_j};
            addr_b = {r_poly, w_jl};
        end else if (w_wr) begin
            addr_a = {r_poly, r_ja_p[DEPTH-1]};
            addr_b = {r_poly, r_jb_p[DEPTH-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bfly  <= 7'd0;
            r_phase <= 1'b0;
            r_layer <= 3'd0;
            r_poly  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_poly  <= poly_sel;
                        r_layer <= 3'd0;
                        r_bfly  <= 7'd0;
                        r_phase <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) r_bfly <= r_bfly + 7'd1;
                end
                S_DRAIN: begin
                    if (!w_inflight && (r_layer != 3'd6)) begin
                        r_layer <= r_layer + 3'd1;
                        r_bfly  <= 7'd0;
                        r_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back delay line: stage 0 is aligned with RAM read data, last stage with the write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_ja_p[0] <= w_j;
        r_jb_p[0] <= w_jl;
        for (int i = 1; i < DEPTH; i++) begin
            r_ja_p[i] <= r_ja_p[i-1];
            r_jb_p[i] <= r_jb_p[i-1];
        end
        if (w_rd) r_k_p0 <= w_k;
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: cycle-exact schedule model built from the reference NTT loop nest,
// a RAM + butterfly model driven by the DUT, and directed literal checks.
module tb_ntt_addr_gen;

    localparam int Q = 3329;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0, psel0 = 1'b0, psel1 = 1'b0;
    logic       busy0, done0, we_a0, we_b0, rd0, bfv0;
    logic       busy1, done1, we_a1, we_b1, rd1, bfv1;
    logic [8:0] aa0, ab0, aa1, ab1;
    logic [6:0] z0, z1;
    logic [2:0] ly0, ly1;

    ntt_addr_gen #(.BF_LAT(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .poly_sel(psel0), .busy(busy0), .done(done0),
        .addr_a(aa0), .addr_b(ab0), .we_a(we_a0), .we_b(we_b0), .rd_issue(rd0),
        .bf_in_valid(bfv0), .zeta_idx(z0), .layer(ly0));

    ntt_addr_gen #(.BF_LAT(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .poly_sel(psel1), .busy(busy1), .done(done1),
        .addr_a(aa1), .addr_b(ab1), .we_a(we_a1), .we_b(we_b1), .rd_issue(rd1),
        .bf_in_valid(bfv1), .zeta_idx(z1), .layer(ly1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int ej[896], ejl[896], ek[896];
    int zetas[128];
    int ram[512], sw[512], wcnt[512];
    int qa = 0, qb = 0, nwrites = 0;
    int res_q[$];

    bit sel = 1'b0, mon_on = 1'b0, model_on = 1'b0, mon_poly = 1'b0;
    int mon_s = 0, mon_bl = 2, mon_tmax = 0;

    logic       m_busy, m_done, m_we_a, m_we_b, m_rd, m_bfv;
    logic [8:0] m_aa, m_ab;
    logic [6:0] m_z;
    logic [2:0] m_ly;
    always_comb begin
        m_busy = sel ? busy1 : busy0;  m_done = sel ? done1 : done0;
        m_we_a = sel ? we_a1 : we_a0;  m_we_b = sel ? we_b1 : we_b0;
        m_rd   = sel ? rd1   : rd0;    m_bfv  = sel ? bfv1  : bfv0;
        m_aa   = sel ? aa1   : aa0;    m_ab   = sel ? ab1   : ab0;
        m_z    = sel ? z1    : z0;     m_ly   = sel ? ly1   : ly0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bfly(input int a, input int b, input int z, output int na, output int nb);
        int t;
        t  = (z * b) % Q;
        na = (a + t) % Q;
        nb = (a - t + Q) % Q;
    endtask

    task automatic sw_ntt(input int base);
        int k, na, nb;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    bfly(sw[base + j], sw[base + j + len], zetas[k], na, nb);
                    sw[base + j] = na;
                    sw[base + j + len] = nb;
                end
                k++;
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input bit which, input bit p, output int s);
        s = cyc;
        mon_s = s;
        mon_on = 1'b1;
        if (which) begin start1 = 1'b1; psel1 = p; end
        else       begin start0 = 1'b1; psel0 = p; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Per-cycle schedule check and RAM/butterfly emulation
    always @(negedge clk) begin
        int t, p, l, r, w, idx, na, nb;
        logic e_busy, e_done, e_rd, e_we, e_bfv;
        logic [8:0] e_aa, e_ab;
        logic [6:0] e_z;
        logic [2:0] e_ly, a_ly;
        logic [33:0] ev, av;
        checks++;
        if ((rd0 && we_a0) || (we_a0 !== we_b0) || (rd1 && we_a1) || (we_a1 !== we_b1)) begin
            failures++;
            $display("FAIL port_excl cyc=%0d: rd0=%b we0=%b/%b rd1=%b we1=%b/%b required no rd&we, we_a==we_b",
                     cyc, rd0, we_a0, we_b0, rd1, we_a1, we_b1);
        end
        if (mon_on) begin
            t = cyc - mon_s;
            p = 256 + mon_bl;
            if (t >= 1 && t <= mon_tmax) begin
                e_busy = 0; e_done = 0; e_rd = 0; e_we = 0; e_bfv = 0;
                e_aa = 0; e_ab = 0; e_z = 0; e_ly = 0; a_ly = 0;
                if (t <= 7 * p) begin
                    l = (t - 1) / p;
                    r = (t - 1) % p;
                    e_busy = 1; e_ly = 3'(l); a_ly = m_ly;
                    if (r <= 254 && r % 2 == 0) begin
                        idx = l * 128 + r / 2;
                        e_rd = 1;
                        e_aa = {mon_poly, 8'(ej[idx])};
                        e_ab = {mon_poly, 8'(ejl[idx])};
                    end
                    if (r >= 1 && r <= 255 && (r - 1) % 2 == 0) begin
                        e_bfv = 1;
                        e_z = 7'(ek[l * 128 + (r - 1) / 2]);
                    end
                    w = r - 1 - mon_bl;
                    if (w >= 0 && w <= 254 && w % 2 == 0) begin
                        idx = l * 128 + w / 2;
                        e_we = 1;
                        e_aa = {mon_poly, 8'(ej[idx])};
                        e_ab = {mon_poly, 8'(ejl[idx])};
                    end
                end else if (t == 7 * p + 1) begin
                    e_busy = 1; e_done = 1;
                end
                ev = {e_busy, e_done, e_rd, e_we, e_we, e_bfv, e_aa, e_ab, e_z, e_ly};
                av = {m_busy, m_done, m_rd, m_we_a, m_we_b, m_bfv, m_aa, m_ab, m_z, a_ly};
                checks++;
                if (av !== ev) begin
                    failures++;
                    $display("FAIL sched t=%0d: got %h expected %h {busy,done,rd,we_a,we_b,bfv,aa,ab,z,layer}",
                             t, av, ev);
                end
            end
        end
        if (model_on) begin
            if (m_bfv) begin
                bfly(qa, qb, zetas[m_z], na, nb);
                res_q.push_back(na);
                res_q.push_back(nb);
            end
            if (m_rd) begin
                qa = ram[m_aa];
                qb = ram[m_ab];
            end
            if (m_we_a) begin
                if (res_q.size() >= 2) begin
                    ram[m_aa] = res_q.pop_front();
                    ram[m_ab] = res_q.pop_front();
                end
                wcnt[m_aa]++;
                wcnt[m_ab]++;
                nwrites++;
            end
        end
    end

    task automatic prep_ram(input int base);
        for (int i = 0; i < 512; i++) begin
            ram[i] = $urandom_range(0, Q - 1);
            sw[i] = ram[i];
            wcnt[i] = 0;
        end
        sw_ntt(base);
        nwrites = 0;
        res_q.delete();
        qa = 0;
        qb = 0;
    endtask

    task automatic check_ram(input string tag, input int base);
        int bad_data, bad_cnt;
        bad_data = 0;
        bad_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            if (ram[i] != sw[i]) bad_data++;
            if (wcnt[i] != (((i / 256) == (base / 256)) ? 7 : 0)) bad_cnt++;
        end
        check({tag, "_ram_mismatches"}, bad_data, 0);
        check({tag, "_write_count"}, nwrites, 896);
        check({tag, "_addr_not_7x"}, bad_cnt, 0);
    endtask

    initial begin
        int idx, k, e, v, s, c6, dcyc, first1, ndone, nbusy;
        idx = 0;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    ej[idx] = j; ejl[idx] = j + len; ek[idx] = k; idx++;
                end
                k++;
            end
        end
        for (int i = 0; i < 128; i++) begin
            e = 0;
            for (int bt = 0; bt < 7; bt++) if (((i >> bt) & 1) == 1) e = e | (1 << (6 - bt));
            v = 1;
            for (int n = 0; n < e; n++) v = (v * 17) % Q;
            zetas[i] = v;
        end
        check("model_l0_first", ej[0] * 1000 + ejl[0], 128);
        check("model_l6_b2", ej[770] * 1000 + ejl[770], 4006);
        check("model_k_last", ek[895], 127);
        check("model_zeta1", zetas[1], 1729);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_u0_outs", int'({busy0, done0, we_a0, we_b0, rd0, bfv0, aa0, ab0, z0, ly0}), 0);
        check("rst_u1_outs", int'({busy1, done1, we_a1, we_b1, rd1, bfv1, aa1, ab1, z1, ly1}), 0);

        // Run 1: poly 1, stray start mid-run, reset at s+500
        sel = 1'b0; mon_bl = 2; mon_poly = 1'b1; mon_tmax = 499;
        do_start(1'b0, 1'b1, s);
        check("s1_rd_issue", int'(rd0), 1);
        check("s1_addr_a", int'(aa0), 256);
        check("s1_addr_b", int'(ab0), 384);
        wait_until(s + 2);
        check("s2_bf_in_valid", int'(bfv0), 1);
        check("s2_zeta_idx", int'(z0), 1);
        wait_until(s + 4);
        check("s4_we", int'({we_a0, we_b0}), 3);
        check("s4_addr_a", int'(aa0), 256);
        check("s4_addr_b", int'(ab0), 384);
        wait_until(s + 100);
        start0 = 1'b1;
        psel0 = 1'b0;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_until(s + 500);
        rst = 1'b1;
        wait_until(s + 501);
        mon_on = 1'b0;
        check("rst_mid_we", int'(we_a0), 0);
        check("rst_mid_busy", int'(busy0), 0);
        rst = 1'b0;
        ndone = 0;
        nbusy = 0;
        repeat (1400) begin
            @(posedge clk);
            #1;
            if (done0) ndone++;
            if (busy0 || we_a0) nbusy++;
        end
        check("rst_no_done", ndone, 0);
        check("rst_stays_idle", nbusy, 0);

        // Run 2: poly 0 full transform, BF_LAT=2
        prep_ram(0);
        model_on = 1'b1;
        mon_poly = 1'b0; mon_tmax = 7 * 258 + 3;
        do_start(1'b0, 1'b0, s);
        c6 = s + 1 + 6 * 258;
        wait_until(c6);
        check("l6_r0", int'({aa0, ab0}), (0 << 9) | 2);
        wait_until(c6 + 1);
        check("l6_k0", int'(z0), 64);
        wait_until(c6 + 2);
        check("l6_r1", int'({aa0, ab0}), (1 << 9) | 3);
        wait_until(c6 + 3);
        check("l6_k1", int'(z0), 64);
        wait_until(c6 + 4);
        check("l6_r2", int'({aa0, ab0}), (4 << 9) | 6);
        wait_until(c6 + 5);
        check("l6_k2", int'(z0), 65);
        wait_until(c6 + 254);
        check("l6_rlast", int'({aa0, ab0}), (253 << 9) | 255);
        wait_until(c6 + 255);
        check("l6_klast", int'(z0), 127);
        dcyc = -1;
        for (int n = 0; n < 400 && dcyc < 0; n++) begin
            if (done0) dcyc = cyc;
            else begin @(posedge clk); #1; end
        end
        check("run2_done_cycle", dcyc - s, 1807);
        repeat (4) @(posedge clk);
        #1;
        model_on = 1'b0;
        mon_on = 1'b0;
        check_ram("run2", 0);

        // Run 3: poly 1, BF_LAT=4 instance
        sel = 1'b1;
        prep_ram(256);
        model_on = 1'b1;
        mon_bl = 4; mon_poly = 1'b1; mon_tmax = 7 * 260 + 3;
        do_start(1'b1, 1'b1, s);
        first1 = -1;
        for (int n = 0; n < 600 && first1 < 0; n++) begin
            if (rd1 && ly1 == 3'd1) first1 = cyc;
            else begin @(posedge clk); #1; end
        end
        check("bl4_layer_period", first1 - (s + 1), 260);
        dcyc = -1;
        for (int n = 0; n < 2200 && dcyc < 0; n++) begin
            if (done1) dcyc = cyc;
            else begin @(posedge clk); #1; end
        end
        check("run3_done_cycle", dcyc - s, 1821);
        repeat (4) @(posedge clk);
        #1;
        model_on = 1'b0;
        mon_on = 1'b0;
        check_ram("run3", 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
